uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte FIFO between the UART receiver and its consumers (loopback/echo logic, LCD text path). It captures every `uart_done` pulse from `uart_recv` into a power-of-two ring buffer, so a slow or busy consumer does not lose characters. The consumer drains it with a simple read-enable handshake. It runs entirely in the 12.5 MHz UART clock domain.

## Interface
- `ADDR_W`, 4, address width; depth `DEPTH = 2**ADDR_W` entries (16 by default)
- `sys_clk`  input  1  UART domain clock (12.5 MHz)
- `sys_rst_n`  input  1  asynchronous active-low reset
- `recv_done`  input  1  byte-valid strobe from receiver; every high cycle is one push request
- `recv_data`  input  8  received byte, valid while `recv_done`=1
- `rd_en`  input  1  pop request from consumer
- `rd_data`  output  8  read data (timing per Configuration)
- `empty`  output  1  no stored bytes
- `full`  output  1  `DEPTH` stored bytes
- `count`  output  ADDR_W+1  stored bytes, 0..DEPTH
- `overflow`  output  1  sticky: a push was dropped because the FIFO was full
- `clr_ovf`  input  1  clears `overflow`

## Operation
- Storage: `DEPTH` x 8 register array, not reset. `wr_ptr`/`rd_ptr` are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0. `count` is a separate ADDR_W+1 counter.
- Push accepted iff `recv_done && !full`: `mem[wr_ptr] <= recv_data`, `wr_ptr++`.
- Pop accepted iff `rd_en && !empty`: `rd_ptr++`.
- `full` and `empty` are evaluated on the registered state at the start of the cycle.
  - Full with push and pop in the same cycle: pop accepted, push dropped, overflow set.
  - Empty with push and pop in the same cycle: push accepted, pop ignored.
- Count update: +1 for push only, -1 for pop only, unchanged for both or neither.
- `empty = (count==0)`, `full = (count==DEPTH)`. Both are decoded from the registered count, so there is no combinational path from the inputs.
- Push request while full: the byte is discarded, pointers and contents are unchanged, and `overflow <= 1`.
- `rd_en` while empty: no effect. No underflow flag.
- `clr_ovf` clears `overflow` next cycle. A new overflow in the same cycle wins (`overflow` stays 1).
- The block does no edge detection on `recv_done`. A strobe held N cycles produces N pushes of the same byte.
- Reset, including mid-operation: pointers, `count`, `overflow` and `rd_data` go to 0. Stored bytes are lost. The first push after reset lands in entry 0.

## Timing
- Reset values: `rd_data`=8'h00, `empty`=1, `full`=0, `count`=0, `overflow`=0.
- Push to visibility: byte written at the clock edge of the `recv_done` cycle. `empty`/`count` reflect it the following cycle.
- Pop: `count`/`empty`/`full` update at the edge ending the `rd_en` cycle.
- Throughput: one push and one pop per cycle, sustained.
- Default build (registered read): `rd_data <= mem[rd_ptr]` on an accepted pop.
  - Valid the cycle after `rd_en` (1-cycle latency).
  - Holds its value otherwise, including after the FIFO empties.

## Configuration
- Macro `UART_RX_FIFO_FWFT_EN`.
- Defined: first-word fall-through.
  - `rd_data = empty ? 8'h00 : mem[rd_ptr]` combinationally from registered state.
  - The head byte is visible whenever `empty`=0. `rd_en` acknowledges it, and the next byte (or 8'h00) appears the following cycle.
- Undefined: registered read with 1-cycle latency, as in Timing.
- Push/pop rules, flags and count are identical in both builds.

## Test plan
- Reset, then idle -> `empty`=1, `full`=0, `count`=0, `rd_data`=0x00, `overflow`=0.
- Push one-cycle strobes 0x41, 0x42, 0x43; then `rd_en` for one cycle three times -> `rd_data` = 0x41, 0x42, 0x43, each one cycle after its `rd_en`; `empty`=1 after the third pop; `count` goes 3, 2, 1, 0.
- Push 0x00..0x0F, then push 0xAA -> `full`=1, `count`=16, `overflow`=1. Draining returns exactly 0x00..0x0F; 0xAA never appears. `clr_ovf` pulse -> `overflow`=0.
- Pointer wrap with simultaneous events: push 5, then 40 cycles of simultaneous push (0x10+i) and `rd_en` -> `count` stays 5 throughout and the output sequence is strictly in order. With the FIFO full, push + `rd_en` together -> `count`=15, `overflow`=1. With the FIFO empty, push + `rd_en` together -> `count`=1.
- `rd_en` while empty -> no state change. `clr_ovf` in the same cycle as an overflowing push -> `overflow`=1. Assert reset with `count`=7 -> all outputs return to reset values; push 0x55 and pop it -> `rd_data`=0x55.
- With `UART_RX_FIFO_FWFT_EN` defined: push 0x41 -> `rd_data`=0x41 on the cycle after the push, with no `rd_en`. Push 0x42, then `rd_en` -> `rd_data`=0x42 the next cycle. After the final pop -> `rd_data`=0x00.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: push/pop/status bundle between the UART receiver,
// the receive FIFO and its consumer.
// master = receiver/consumer side, slave = FIFO side.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              recv_done;
    logic [7:0]        recv_data;
    logic              rd_en;
    logic              clr_ovf;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output recv_done, recv_data, rd_en, clr_ovf,
        input  rd_data, empty, full, count, overflow
    );

    modport slave (
        input  recv_done, recv_data, rd_en, clr_ovf,
        output rd_data, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte ring buffer in the UART clock domain.
// Every recv_done cycle is one push; the consumer pops with rd_en.
// Optional macro UART_RX_FIFO_FWFT_EN selects first-word fall-through
// read data; without it rd_data is registered with one cycle of latency.
module uart_rx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    uart_rx_fifo_if.slave   fifo_if
);
    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              empty_w, full_w;
    logic              push, pop;

    // Flags come only from the registered count: no input-to-flag path.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // Accept/drop decisions and next-state for pointers, count, overflow.
    always_comb begin
        push       = fifo_if.recv_done && !full_w;
        pop        = fifo_if.rd_en && !empty_w;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A dropped push in the same cycle as clr_ovf keeps the flag set.
        if (fifo_if.recv_done && full_w) overflow_d = 1'b1;
        else if (fifo_if.clr_ovf)        overflow_d = 1'b0;
    end

    // Control state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage: written on accepted pushes, never reset.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= fifo_if.recv_data;
    end

`ifdef UART_RX_FIFO_FWFT_EN
    // Head byte is presented whenever the FIFO holds data.
    assign fifo_if.rd_data = empty_w ? 8'h00 : mem_q[rd_ptr_q];
`else
    logic [7:0] rd_data_q, rd_data_d;

    // Load the head byte on an accepted pop, hold it otherwise.
    always_comb begin
        rd_data_d = rd_data_q;
        if (pop) rd_data_d = mem_q[rd_ptr_q];
    end

    // Registered read data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rd_data_q <= 8'h00;
        else            rd_data_q <= rd_data_d;
    end

    assign fifo_if.rd_data = rd_data_q;
`endif

    assign fifo_if.empty    = empty_w;
    assign fifo_if.full     = full_w;
    assign fifo_if.count    = count_q;
    assign fifo_if.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with a queue-based scoreboard.
// The driver keeps a byte-queue model of the FIFO; every accepted pop
// pushes the expected byte into exp_q, and an independent monitor pops
// and compares whenever the DUT presents read data.
module tb_uart_rx_fifo;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    uart_rx_fifo_if #(.ADDR_W(ADDR_W)) fif ();

    uart_rx_fifo #(.ADDR_W(ADDR_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .fifo_if   (fif)
    );

    always #40 sys_clk = ~sys_clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_rd  = 8'h00;
    logic       mon_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " count"},    32'(fif.count),    32'(mq.size()));
        chk({tag, " empty"},    32'(fif.empty),    32'(mq.size() == 0));
        chk({tag, " full"},     32'(fif.full),     32'(mq.size() == DEPTH));
        chk({tag, " overflow"}, 32'(fif.overflow), 32'(m_ovf));
        chk({tag, " rd_data"},  32'(fif.rd_data),  32'(m_rd));
    endtask

    task automatic compare_out();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected output: got %0h, expected none", fif.rd_data);
        end else begin
            chk("pop data", 32'(fif.rd_data), 32'(exp_q.pop_front()));
        end
    endtask

    // One clock of stimulus; model updated from pre-edge state.
    task automatic step(input logic done, input logic [7:0] data, input logic rd,
                        input logic clr, input string tag);
        bit full_m, empty_m;
        logic [7:0] b;
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        fif.recv_done = done;
        fif.recv_data = data;
        fif.rd_en     = rd;
        fif.clr_ovf   = clr;
        if (rd && !empty_m) begin
            b = mq.pop_front();
            exp_q.push_back(b);
`ifndef UART_RX_FIFO_FWFT_EN
            m_rd = b;
`endif
        end
        if (done && !full_m) mq.push_back(data);
        if (done && full_m) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        @(posedge sys_clk);
`ifdef UART_RX_FIFO_FWFT_EN
        m_rd = (mq.size() != 0) ? mq[0] : 8'h00;
`endif
        @(negedge sys_clk);
        check_state(tag);
        #1;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        while (mq.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0, tag);
    endtask

`ifdef UART_RX_FIFO_FWFT_EN
    // Head byte must be on rd_data while rd_en acknowledges it.
    initial forever begin
        @(negedge sys_clk);
        #20;
        if (fif.rd_en && !fif.empty && sys_rst_n) compare_out();
    end
`else
    // Data appears the cycle after an accepted pop.
    initial forever begin
        @(posedge sys_clk);
        mon_p = fif.rd_en && !fif.empty && sys_rst_n;
        @(negedge sys_clk);
        if (mon_p) compare_out();
    end
`endif

    initial begin
        #(80 * 20000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fif.recv_done = 1'b0;
        fif.recv_data = 8'h00;
        fif.rd_en     = 1'b0;
        fif.clr_ovf   = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_state("reset");
        #1;
        sys_rst_n = 1'b1;
        idle("idle");

        // Three single-cycle strobes, then three spaced pops.
        step(1'b1, 8'h41, 1'b0, 1'b0, "push41");
        step(1'b1, 8'h42, 1'b0, 1'b0, "push42");
        step(1'b1, 8'h43, 1'b0, 1'b0, "push43");
        idle("idle3");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "pop_abc");
            idle("pop_abc_gap");
        end

        // Fill, overflow with 0xAA, drain, clear the sticky flag.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 8'hAA, 1'b0, 1'b0, "push_full");
        drain("drain_full");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");

        // Wrap pointers with simultaneous push and pop.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, "pre5");
        for (int i = 0; i < 40; i++) step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, "both");
        drain("drain_wrap");

        // Full with push+pop: pop wins, push dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, "fill2");
        step(1'b1, 8'hBB, 1'b1, 1'b0, "full_both");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr2");
        drain("drain2");

        // Empty with push+pop: push accepted, pop ignored.
        step(1'b1, 8'hCC, 1'b1, 1'b0, "empty_both");
        drain("drain3");

        // Pop while empty: nothing changes.
        step(1'b0, 8'h00, 1'b1, 1'b0, "pop_empty");
        idle("pop_empty_after");

        // clr_ovf with an overflowing push: overflow stays set.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, "fill3");
        step(1'b1, 8'hDD, 1'b0, 1'b1, "ovf_vs_clr");
        drain("drain4");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr3");

        // Reset mid-operation with seven bytes stored.
        for (int i = 0; i < 7; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, "pre_rst");
        sys_rst_n = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_rd  = 8'h00;
        @(negedge sys_clk);
        check_state("mid_reset");
        #1;
        sys_rst_n = 1'b1;
        step(1'b1, 8'h55, 1'b0, 1'b0, "push55");
        step(1'b0, 8'h00, 1'b1, 1'b0, "pop55");
        idle("end1");
        idle("end2");

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
